m_wb_arb: RTL and testbench
===========================

Name: m_wb_arb

Overview:
- Writeback arbiter: the write-side driver of the 32x32 register file's single write port (w_we/w_wa/w_wd).
- Merges two result sources:
  - the single-cycle ALU path, which cannot be buffered;
  - a long-latency path (load/mul), with valid/ready handshake and a small FIFO.
- Sits between EX/MEM result producers and the register file.
- Guarantees at most one RF write per cycle and never writes x0.

Parameters:
- DEPTH, 4: long-latency FIFO entries; power of two, >=2.
- STARVE_LIM, 3: consecutive cycles the FIFO head may lose to the ALU before it is forced through.

Ports:
- w_clk  in  1  clock; all state updates on posedge.
- w_rst  in  1  synchronous active-high reset, sampled on posedge w_clk.
- w_alu_v  in  1  ALU result valid this cycle.
- w_alu_rd  in  5  ALU destination register.
- w_alu_d  in  32  ALU result data.
- w_stall  out  1  ALU result not accepted this cycle; pipeline must hold w_alu_* stable.
- w_lng_v  in  1  long-latency result valid.
- w_lng_rd  in  5  long-latency destination register.
- w_lng_d  in  32  long-latency result data.
- w_lng_rdy  out  1  FIFO can accept; a push occurs when w_lng_v & w_lng_rdy.
- w_we  out  1  RF write enable (registered).
- w_wa  out  5  RF write address (registered).
- w_wd  out  32  RF write data (registered).
- w_cnt  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (w_rst=1 at posedge):
  - w_we=0, w_wa=0, w_wd=0;
  - FIFO empty, w_cnt=0, rd/wr pointers 0;
  - starve counter 0.
  - Reset mid-operation discards all FIFO contents and any pending write.
- w_lng_rdy = (w_cnt != DEPTH), combinational. A push never occurs while full.
- Grant, evaluated combinationally each cycle:
  - force = (FIFO nonempty) & (starve_cnt == STARVE_LIM).
  - If force: grant FIFO head; w_stall = w_alu_v.
  - Else if w_alu_v: grant ALU; w_stall=0.
  - Else if FIFO nonempty: grant FIFO head (pop).
  - Else: no grant.
  - w_stall is 0 in every other case.
- Starve counter, updated each posedge:
  - cleared on any pop or when FIFO is empty;
  - otherwise incremented when FIFO is nonempty and ALU wins;
  - saturates at STARVE_LIM.
- Output register (1-cycle latency): the granted {rd, data} loads into w_wa/w_wd on the next posedge.
  - w_we = granted & (rd != 0).
  - A grant with rd=0 still pops/consumes but produces w_we=0.
  - With no grant, w_we=0 and w_wa/w_wd hold their previous values.
- FIFO:
  - Circular buffer, wrap-around pointers.
  - Push and pop in the same cycle when nonempty and not full: w_cnt unchanged, order preserved.
  - Push into empty FIFO: the entry is not eligible until the next cycle; no bypass.
- Ordering: FIFO entries retire in push order. ALU vs FIFO ordering to the same rd is the producer's responsibility; the hazard unit must not issue a conflicting ALU write.

Decomposition:
- Shared package/constants file:
  - XLEN=32, REG_AW=5, REG_ZERO=5'd0;
  - wb entry layout {rd[4:0], data[31:0]} (37 bits).
- One natural sub-module: m_wb_fifo (parameterised DEPTH; push/pop/full/empty/count; head read combinational).

Test Plan:
- Reset: assert w_rst 2 cycles with w_alu_v=1 -> w_we=0, w_cnt=0, w_lng_rdy=1 throughout; first write appears 1 cycle after w_rst drops.
- ALU only: w_alu_v=1, rd=5, d=32'h1234 for one cycle -> next cycle w_we=1, w_wa=5, w_wd=32'h1234; w_stall=0.
- x0 suppression: ALU rd=0, then lng rd=0 d=32'hDEAD -> w_we stays 0; FIFO returns to w_cnt=0.
- Fill/full: ALU valid every cycle, push 4 lng results (rd=1..4) -> w_cnt reaches 4, w_lng_rdy=0. A 5th w_lng_v is not accepted; w_cnt stays 4.
- Starvation: continue ALU valid with FIFO full -> after 3 ALU wins, w_stall=1 for one cycle and rd=1 is written. Counter clears; the pattern repeats until rd=1..4 drain in order.
- Simultaneous push/pop: w_cnt=2, ALU idle, lng push rd=7 -> head written next cycle, w_cnt stays 2. Final write order matches push order, including pointer wrap past DEPTH.

Source files
------------

// File: rtl/m_wb_arb_pkg.sv
// Shared constants and types for the writeback arbiter and its result FIFO.
package m_wb_arb_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // One pending register-file write: {rd, data}.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  localparam int unsigned WB_ENTRY_W = $bits(wb_entry_t);

  typedef enum logic [1:0] {
    GntNone,
    GntAlu,
    GntFifo
  } grant_e;

endpackage

// File: rtl/m_wb_fifo.sv
// Circular FIFO holding long-latency results; head is read combinationally.
module m_wb_fifo
  import m_wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  wb_entry_t                push_data_i,
  input  logic                     pop_i,
  output wb_entry_t                head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/m_wb_arb.sv
// Writeback arbiter: merges the unbufferable ALU result with queued long-latency
// results onto the single register-file write port, with starvation protection.
module m_wb_arb
  import m_wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic                   w_clk,
  input  logic                   w_rst,
  input  logic                   w_alu_v,
  input  logic [REG_AW-1:0]      w_alu_rd,
  input  logic [XLEN-1:0]        w_alu_d,
  output logic                   w_stall,
  input  logic                   w_lng_v,
  input  logic [REG_AW-1:0]      w_lng_rd,
  input  logic [XLEN-1:0]        w_lng_d,
  output logic                   w_lng_rdy,
  output logic                   w_we,
  output logic [REG_AW-1:0]      w_wa,
  output logic [XLEN-1:0]        w_wd,
  output logic [$clog2(DEPTH):0] w_cnt
);

  localparam int unsigned StW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

  wb_entry_t        head, push_ent, gnt_ent;
  logic             fifo_full, fifo_empty, force_pop, pop;
  grant_e           gnt;
  logic [StW-1:0]   starve_q, starve_d;
  logic             we_q;
  logic [REG_AW-1:0] wa_q;
  logic [XLEN-1:0]  wd_q;

  assign push_ent = '{rd: w_lng_rd, data: w_lng_d};

  m_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (w_clk),
    .rst_i       (w_rst),
    .push_i      (w_lng_v),
    .push_data_i (push_ent),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .cnt_o       (w_cnt)
  );

  assign w_lng_rdy = ~fifo_full;
  assign force_pop = ~fifo_empty & (starve_q == StW'(STARVE_LIM));

  always_comb begin
    gnt     = GntNone;
    w_stall = 1'b0;
    if (force_pop) begin
      gnt     = GntFifo;
      w_stall = w_alu_v;
    end else if (w_alu_v) begin
      gnt = GntAlu;
    end else if (!fifo_empty) begin
      gnt = GntFifo;
    end
  end

  assign pop = (gnt == GntFifo);

  always_comb begin
    gnt_ent = head;
    if (gnt == GntAlu) gnt_ent = '{rd: w_alu_rd, data: w_alu_d};
  end

  // Counts consecutive ALU wins over a waiting head; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q != StW'(STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      starve_q <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      starve_q <= starve_d;
      we_q     <= (gnt != GntNone) && (gnt_ent.rd != REG_ZERO);
      if (gnt != GntNone) begin
        wa_q <= gnt_ent.rd;
        wd_q <= gnt_ent.data;
      end
    end
  end

  assign w_we = we_q;
  assign w_wa = wa_q;
  assign w_wd = wd_q;

endmodule

// File: tb/tb_m_wb_arb.sv
// Self-checking bench for m_wb_arb against a queue-based reference model.
module tb_m_wb_arb;

  localparam int DEPTH = 4;
  localparam int LIM   = 3;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_alu_v = 1'b0;
  logic [4:0]  w_alu_rd = '0;
  logic [31:0] w_alu_d = '0;
  logic        w_stall;
  logic        w_lng_v = 1'b0;
  logic [4:0]  w_lng_rd = '0;
  logic [31:0] w_lng_d = '0;
  logic        w_lng_rdy;
  logic        w_we;
  logic [4:0]  w_wa;
  logic [31:0] w_wd;
  logic [2:0]  w_cnt;

  m_wb_arb #(
    .DEPTH      (DEPTH),
    .STARVE_LIM (LIM)
  ) dut (
    .w_clk     (w_clk),
    .w_rst     (w_rst),
    .w_alu_v   (w_alu_v),
    .w_alu_rd  (w_alu_rd),
    .w_alu_d   (w_alu_d),
    .w_stall   (w_stall),
    .w_lng_v   (w_lng_v),
    .w_lng_rd  (w_lng_rd),
    .w_lng_d   (w_lng_d),
    .w_lng_rdy (w_lng_rdy),
    .w_we      (w_we),
    .w_wa      (w_wa),
    .w_wd      (w_wd),
    .w_cnt     (w_cnt)
  );

  always #5 w_clk = ~w_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending long results as a queue, plus the expected RF write.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          m_starve = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  int          e_grant;  // 0 none, 1 alu, 2 fifo head
  logic        e_stall, e_rdy;

  task automatic model_comb();
    bit forced;
    forced  = (mq.size() > 0) && (m_starve == LIM);
    e_stall = 1'b0;
    e_grant = 0;
    if (forced) begin
      e_grant = 2;
      e_stall = w_alu_v;
    end else if (w_alu_v) begin
      e_grant = 1;
    end else if (mq.size() > 0) begin
      e_grant = 2;
    end
    e_rdy = (mq.size() < DEPTH);
  endtask

  task automatic model_seq();
    ent_t g;
    bit   was_empty;
    bit   push;
    if (w_rst) begin
      mq.delete();
      m_starve = 0;
      m_we = 1'b0;
      m_wa = '0;
      m_wd = '0;
    end else begin
      was_empty = (mq.size() == 0);
      push = w_lng_v && e_rdy;
      g.rd = '0;
      g.d  = '0;
      if (e_grant == 1) begin
        g.rd = w_alu_rd;
        g.d  = w_alu_d;
      end else if (e_grant == 2) begin
        g = mq.pop_front();
      end
      if (push) mq.push_back('{rd: w_lng_rd, d: w_lng_d});
      if (e_grant == 2 || was_empty) m_starve = 0;
      else if (m_starve < LIM) m_starve++;
      if (e_grant != 0) begin
        m_we = (g.rd != 5'd0);
        m_wa = g.rd;
        m_wd = g.d;
      end else begin
        m_we = 1'b0;
      end
    end
  endtask

  task automatic clk_step();
    @(posedge w_clk);
    model_seq();
    #1;
  endtask

  task automatic test_reset();
    w_rst = 1'b1; w_alu_v = 1'b1; w_alu_rd = 5'd3; w_alu_d = 32'hA5A5_0003;
    w_lng_v = 1'b0;
    for (int c = 0; c < 2; c++) begin
      model_comb();
      clk_step();
      n_checks++;
      if (w_we !== 1'b0) begin
        n_errors++; $display("FAIL reset_we: got %0b want 0", w_we);
      end
      n_checks++;
      if (w_cnt !== 3'd0) begin
        n_errors++; $display("FAIL reset_cnt: got %0d want 0", w_cnt);
      end
      n_checks++;
      if (w_lng_rdy !== 1'b1) begin
        n_errors++; $display("FAIL reset_rdy: got %0b want 1", w_lng_rdy);
      end
    end
    n_checks++;
    if (w_wa !== 5'd0 || w_wd !== 32'd0) begin
      n_errors++; $display("FAIL reset_wa_wd: got %0d/%0h want 0/0", w_wa, w_wd);
    end
    w_rst = 1'b0;
    #1 model_comb();
    clk_step();
    n_checks++;
    if (w_we !== 1'b1 || w_wa !== 5'd3 || w_wd !== 32'hA5A5_0003) begin
      n_errors++;
      $display("FAIL reset_first_write: got we=%0b wa=%0d wd=%0h want 1/3/a5a50003",
               w_we, w_wa, w_wd);
    end
  endtask

  task automatic test_alu_only();
    w_alu_v = 1'b1; w_alu_rd = 5'd5; w_alu_d = 32'h1234; w_lng_v = 1'b0;
    #1 model_comb();
    n_checks++;
    if (w_stall !== 1'b0) begin
      n_errors++; $display("FAIL alu_stall: got %0b want 0", w_stall);
    end
    clk_step();
    n_checks++;
    if (w_we !== 1'b1 || w_wa !== 5'd5 || w_wd !== 32'h1234) begin
      n_errors++;
      $display("FAIL alu_write: got we=%0b wa=%0d wd=%0h want 1/5/1234", w_we, w_wa, w_wd);
    end
    w_alu_v = 1'b0;
    #1 model_comb();
    clk_step();
    n_checks++;
    if (w_we !== 1'b0 || w_wa !== 5'd5 || w_wd !== 32'h1234) begin
      n_errors++;
      $display("FAIL alu_idle_hold: got we=%0b wa=%0d wd=%0h want 0/5/1234", w_we, w_wa, w_wd);
    end
  endtask

  task automatic test_x0();
    w_alu_v = 1'b1; w_alu_rd = 5'd0; w_alu_d = $urandom;
    #1 model_comb();
    clk_step();
    n_checks++;
    if (w_we !== 1'b0) begin
      n_errors++; $display("FAIL x0_alu_we: got %0b want 0", w_we);
    end
    w_alu_v = 1'b0; w_lng_v = 1'b1; w_lng_rd = 5'd0; w_lng_d = 32'hDEAD;
    #1 model_comb();
    clk_step();
    n_checks++;
    if (w_cnt !== 3'd1 || w_we !== 1'b0) begin
      n_errors++; $display("FAIL x0_push: got cnt=%0d we=%0b want 1/0", w_cnt, w_we);
    end
    w_lng_v = 1'b0;
    #1 model_comb();
    clk_step();
    n_checks++;
    if (w_cnt !== 3'd0 || w_we !== 1'b0) begin
      n_errors++; $display("FAIL x0_pop: got cnt=%0d we=%0b want 0/0", w_cnt, w_we);
    end
  endtask

  task automatic test_fill_starve();
    int         pushed = 1;
    int         stalls = 0;
    bit         offered5 = 0;
    bit         hold = 0;
    bit         acc;
    logic [4:0] got[$];
    for (int c = 0; c < 40; c++) begin
      if (!hold) begin
        w_alu_v = 1'b1; w_alu_rd = 5'($urandom_range(10, 31)); w_alu_d = $urandom;
      end
      if (pushed <= 4) begin
        w_lng_v = 1'b1; w_lng_rd = 5'(pushed); w_lng_d = $urandom;
      end else if (!offered5 && mq.size() == DEPTH) begin
        w_lng_v = 1'b1; w_lng_rd = 5'd9; w_lng_d = $urandom;
        offered5 = 1;
      end else begin
        w_lng_v = 1'b0;
      end
      #1 model_comb();
      n_checks++;
      if (w_stall !== e_stall || w_lng_rdy !== e_rdy || w_cnt !== 3'(mq.size())) begin
        n_errors++;
        $display("FAIL fill_comb c%0d: got stall=%0b rdy=%0b cnt=%0d want %0b/%0b/%0d",
                 c, w_stall, w_lng_rdy, w_cnt, e_stall, e_rdy, mq.size());
      end
      if (w_stall === 1'b1) stalls++;
      acc  = w_lng_v && e_rdy;
      hold = e_stall;
      clk_step();
      if (acc && pushed <= 4) pushed++;
      n_checks++;
      if (w_we !== m_we || (m_we && (w_wa !== m_wa || w_wd !== m_wd))) begin
        n_errors++;
        $display("FAIL fill_write c%0d: got we=%0b wa=%0d wd=%0h want %0b/%0d/%0h",
                 c, w_we, w_wa, w_wd, m_we, m_wa, m_wd);
      end
      if (w_we === 1'b1 && (w_wa inside {[5'd1:5'd4], 5'd9})) got.push_back(w_wa);
    end
    n_checks++;
    if (!offered5) begin
      n_errors++; $display("FAIL fill_full_reached: got 0 want 1");
    end
    n_checks++;
    if (got.size() != 4 || got[0] !== 5'd1 || got[1] !== 5'd2 || got[2] !== 5'd3 ||
        got[3] !== 5'd4) begin
      n_errors++; $display("FAIL starve_order: got %p want 1,2,3,4", got);
    end
    n_checks++;
    if (stalls != 4) begin
      n_errors++; $display("FAIL starve_stalls: got %0d want 4", stalls);
    end
    w_alu_v = 1'b0; w_lng_v = 1'b0;
  endtask

  task automatic test_push_pop();
    logic [4:0] pushed[$];
    logic [4:0] got[$];
    logic [4:0] rd;
    w_alu_v = 1'b1; w_alu_rd = 5'd20; w_alu_d = $urandom;
    w_lng_v = 1'b1; w_lng_rd = 5'd11; w_lng_d = $urandom;
    #1 model_comb(); clk_step();
    w_alu_rd = 5'd21; w_lng_rd = 5'd12; w_lng_d = $urandom;
    #1 model_comb(); clk_step();
    pushed.push_back(5'd11); pushed.push_back(5'd12);
    n_checks++;
    if (w_cnt !== 3'd2) begin
      n_errors++; $display("FAIL pp_setup_cnt: got %0d want 2", w_cnt);
    end
    w_alu_v = 1'b0; w_lng_rd = 5'd7; w_lng_d = $urandom;
    #1 model_comb(); clk_step();
    pushed.push_back(5'd7);
    got.push_back(w_wa);
    n_checks++;
    if (w_cnt !== 3'd2 || w_we !== 1'b1 || w_wa !== 5'd11) begin
      n_errors++;
      $display("FAIL pp_simul: got cnt=%0d we=%0b wa=%0d want 2/1/11", w_cnt, w_we, w_wa);
    end
    for (int c = 0; c < 10; c++) begin
      rd = 5'($urandom_range(13, 31));
      w_lng_rd = rd; w_lng_d = $urandom;
      #1 model_comb();
      if (e_rdy) pushed.push_back(rd);
      clk_step();
      if (w_we === 1'b1) got.push_back(w_wa);
      n_checks++;
      if (w_cnt !== 3'(mq.size()) || w_wd !== m_wd) begin
        n_errors++;
        $display("FAIL pp_stream c%0d: got cnt=%0d wd=%0h want %0d/%0h",
                 c, w_cnt, w_wd, mq.size(), m_wd);
      end
    end
    w_lng_v = 1'b0;
    for (int c = 0; c < 20 && mq.size() > 0; c++) begin
      #1 model_comb(); clk_step();
      if (w_we === 1'b1) got.push_back(w_wa);
    end
    n_checks++;
    if (mq.size() != 0 || w_cnt !== 3'd0) begin
      n_errors++; $display("FAIL pp_drain: got cnt=%0d want 0", w_cnt);
    end
    n_checks++;
    if (got != pushed) begin
      n_errors++; $display("FAIL pp_order: got %p want %p", got, pushed);
    end
  endtask

  task automatic test_random();
    bit hold = 0;
    for (int c = 0; c < 400; c++) begin
      w_rst = ($urandom_range(0, 49) == 0);
      if (!hold) begin
        w_alu_v = ($urandom_range(0, 99) < 60);
        w_alu_rd = 5'($urandom_range(0, 31)); w_alu_d = $urandom;
      end
      w_lng_v = ($urandom_range(0, 99) < 45);
      w_lng_rd = 5'($urandom_range(0, 31)); w_lng_d = $urandom;
      #1 model_comb();
      n_checks++;
      if (w_stall !== e_stall || w_lng_rdy !== e_rdy || w_cnt !== 3'(mq.size())) begin
        n_errors++;
        $display("FAIL rand_comb c%0d: got stall=%0b rdy=%0b cnt=%0d want %0b/%0b/%0d",
                 c, w_stall, w_lng_rdy, w_cnt, e_stall, e_rdy, mq.size());
      end
      hold = e_stall && !w_rst;
      clk_step();
      n_checks++;
      if (w_we !== m_we || w_wa !== m_wa || w_wd !== m_wd) begin
        n_errors++;
        $display("FAIL rand_write c%0d: got we=%0b wa=%0d wd=%0h want %0b/%0d/%0h",
                 c, w_we, w_wa, w_wd, m_we, m_wa, m_wd);
      end
    end
    w_rst = 1'b0; w_alu_v = 1'b0; w_lng_v = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_x0();
    test_fill_starve();
    test_push_pop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
